// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: picks up to two non-null write requests per cycle for the two regfile write ports.
// Optional macro WB_ROUND_ROBIN_EN enables rotating priority; otherwise requester 0 always scans first.
module regfile_wb_arbiter #(
  parameter int N_REQ = 4,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wb_stall,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0][5:0]       req_waddr,
  input  logic [N_REQ-1:0][3:0]       req_we,
  input  logic [N_REQ-1:0][31:0]      req_wdata,
  output logic [3:0]                  inst1_we,
  output logic [3:0]                  inst2_we,
  output logic [5:0]                  inst1_waddr,
  output logic [5:0]                  inst2_waddr,
  output logic [31:0]                 inst1_wdata,
  output logic [31:0]                 inst2_wdata,
  output logic                        wb_busy,
  output logic [PTR_W-1:0]            dbg_ptr
);

  // Handshake: a requester transfers in a cycle where req_valid & req_ready are both high.
  // req_ready is combinational from this cycle's inputs; null requests (we==0 or waddr==0)
  // are acknowledged whenever the writeback is not stalled and take no write port.

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [N_REQ-1:0] is_null;
  logic [N_REQ-1:0] eligible;
  logic             win1_vld;
  logic             win2_vld;
  logic [PTR_W-1:0] win1_idx;
  logic [PTR_W-1:0] win2_idx;
  logic [PTR_W-1:0] cand;

  function automatic logic [PTR_W-1:0] scan_idx(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      is_null[i]  = (req_we[i] == 4'd0) || (req_waddr[i] == 6'd0);
      eligible[i] = req_valid[i] && !is_null[i] && !wb_stall;
    end
  end

  // Port 2 skips any candidate aiming at the port-1 address, so both ports never collide.
  always_comb begin
    win1_vld = 1'b0;
    win1_idx = '0;
    win2_vld = 1'b0;
    win2_idx = '0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = scan_idx(ptr, k);
      if (eligible[cand]) begin
        if (!win1_vld) begin
          win1_vld = 1'b1;
          win1_idx = cand;
        end else if (!win2_vld && (req_waddr[cand] != req_waddr[win1_idx])) begin
          win2_vld = 1'b1;
          win2_idx = cand;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = !reset && !wb_stall &&
                     (is_null[i] ||
                      (win1_vld && (win1_idx == PTR_W'(i))) ||
                      (win2_vld && (win2_idx == PTR_W'(i))));
    end
  end

`ifdef WB_ROUND_ROBIN_EN
  always_comb begin
    ptr_next = ptr;
    if (win2_vld)      ptr_next = scan_idx(win2_idx, 1);
    else if (win1_vld) ptr_next = scan_idx(win1_idx, 1);
  end
`else
  assign ptr_next = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      wb_busy     <= 1'b0;
      inst1_we    <= 4'd0;
      inst1_waddr <= 6'd0;
      inst1_wdata <= 32'd0;
      inst2_we    <= 4'd0;
      inst2_waddr <= 6'd0;
      inst2_wdata <= 32'd0;
    end else begin
      ptr         <= ptr_next;
      wb_busy     <= |(req_valid & ~req_ready);
      inst1_we    <= win1_vld ? req_we[win1_idx]    : 4'd0;
      inst1_waddr <= win1_vld ? req_waddr[win1_idx] : 6'd0;
      inst1_wdata <= win1_vld ? req_wdata[win1_idx] : 32'd0;
      inst2_we    <= win2_vld ? req_we[win2_idx]    : 4'd0;
      inst2_waddr <= win2_vld ? req_waddr[win2_idx] : 6'd0;
      inst2_wdata <= win2_vld ? req_wdata[win2_idx] : 32'd0;
    end
  end

  assign dbg_ptr = ptr;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of writeback requesters (2..8).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port wb_stall, input, 1, when high no request is granted this cycle.
REQ-005 SHALL have port req_valid, input, N_REQ, per-requester write request.
REQ-006 SHALL have port req_ready, output, N_REQ, per-requester grant (combinational); transfer when valid&ready.
REQ-007 SHALL have port req_waddr, input, N_REQ x 6, destination register address per requester.
REQ-008 SHALL have port req_we, input, N_REQ x 4, per-byte write enable per requester.
REQ-009 SHALL have port req_wdata, input, N_REQ x 32, write data per requester.
REQ-010 SHALL have ports inst1_we/inst2_we, output, 4 each, registered byte enables to the regfile write ports.
REQ-011 SHALL have ports inst1_waddr/inst2_waddr, output, 6 each, registered write addresses.
REQ-012 SHALL have ports inst1_wdata/inst2_wdata, output, 32 each, registered write data.
REQ-013 SHALL have port wb_busy, output, 1, registered; high when any req_valid was refused in the previous cycle.

Function
REQ-014 A request is null when req_we==0 or req_waddr==0; null requests SHALL get req_ready=1 whenever wb_stall=0 and SHALL consume no write port.
REQ-015 Non-null requests SHALL be scanned from index ptr upward modulo N_REQ; first eligible gets port 1, next eligible gets port 2.
REQ-016 A candidate whose req_waddr equals the port-1 winner's address SHALL be skipped for port 2 (req_ready=0); scan continues to later requesters.
REQ-017 At most two non-null requests SHALL be granted per cycle; all others SHALL see req_ready=0.
REQ-018 With wb_stall=1 all req_ready SHALL be 0 and next-cycle inst1_we/inst2_we SHALL be 0.
REQ-019 Latency: a grant in cycle T SHALL appear on instN_* outputs in cycle T+1; an unused port SHALL drive we=0 in T+1.
REQ-020 Port 1 SHALL always be filled before port 2; inst2_we!=0 implies inst1_we!=0 and inst1_waddr!=inst2_waddr.
REQ-021 req_we and req_wdata SHALL be forwarded unmodified (no byte merging).
REQ-022 ptr SHALL update only in cycles with at least one non-null grant, to (index of last non-null grant + 1) mod N_REQ.
REQ-023 wb_busy SHALL be registered as OR over i of (req_valid[i] & ~req_ready[i]).

Reset
REQ-024 Asserting reset SHALL immediately set inst1/inst2 we, waddr and wdata to 0, wb_busy to 0 and ptr to 0.
REQ-025 During reset req_ready SHALL be 0 for all requesters; first grants SHALL occur in the first cycle after deassertion.
REQ-026 Reset asserted mid-operation SHALL discard any registered write not yet presented; no partial write SHALL reach the outputs.

Configuration
REQ-027 Macro WB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-028 With WB_ROUND_ROBIN_EN defined, ptr SHALL behave per REQ-022.
REQ-029 Without WB_ROUND_ROBIN_EN, ptr SHALL be held at 0 (fixed priority, requester 0 highest); all other behaviour unchanged.

Verification
REQ-030 After reset, valid=4'b0011 with addrs 5 and 6, we=4'hF -> both ready; next cycle inst1_waddr=5 and inst2_waddr=6, we=4'hF, ptr=2.
REQ-031 valid=4'b0111 with all addrs=9 -> only req0 ready; req1 and req2 refused; next cycle inst2_we=0 and wb_busy=1.
REQ-032 req0 addr=0 with we=4'hF, req1 addr=3 with we=4'h1 -> both ready; next cycle inst1_waddr=3, inst1_we=4'h1, inst2_we=0.
REQ-033 All four requesters valid for 4 cycles with distinct addrs, RR on -> grant pairs (0,1),(2,3),(0,1),(2,3); RR off -> (0,1) every cycle.
REQ-034 wb_stall=1 with valid=4'hF -> ready=0 and next-cycle we=0; reset pulsed while inst1_we=4'hF -> outputs 0 immediately, ptr=0.
